// File: rtl/score_pkg.sv
// Shared score-display types and constants.
// Used by the score register block and the BCD converters.
package score_pkg;

  localparam int SCORE_W = 20;
  localparam int SCORE_DIGITS = 7;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  typedef logic [SCORE_DIGITS-1:0][3:0] bcd_digits_t;

endpackage

// File: rtl/score_bcd_converter_if.sv
// Start/busy/done handshake between a score source and its BCD converter.
// master drives the request, slave is the converter.
interface score_bcd_converter_if #(
  parameter int BIN_W = 20,
  parameter int DIGITS = 7
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf
  );

endinterface

// File: rtl/score_bcd_converter_add3_digit.sv
// Double-dabble correction cell: add 3 to a BCD digit of 5 or more.
// Purely combinational.
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/score_bcd_converter.sv
// Iterative binary-to-BCD score converter, one bit per clock.
// Define SCORE_BCD_BLANK_EN to blank leading zero digits with 4'hF.
module score_bcd_converter
  import score_pkg::*;
#(
  parameter int BIN_W = SCORE_W,
  parameter int DIGITS = SCORE_DIGITS
) (
  input logic                  Clk,
  input logic                  Reset_n,
  score_bcd_converter_if.slave sb
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int DW = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);
  localparam logic [DW-1:0] SAT = {DIGITS{4'h9}};

`ifdef SCORE_BCD_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  bcd_state_t state_q, state_d;

  logic [BIN_W-1:0]         shift_q, shift_d;
  logic [DIGITS-1:0][3:0]   dig_q, dig_d;
  logic [DIGITS-1:0][3:0]   adj;
  logic [DIGITS-1:0][3:0]   loaded;
  logic [DW-1:0]            adj_flat, dig_next;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     acc_q, acc_d;
  logic [DW-1:0]            bcd_q, bcd_d;
  logic                     ovf_q, ovf_d;
  logic                     done_q, done_d;
  logic                     carry, top_bad;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .din  (dig_q[g]),
      .dout (adj[g])
    );
  end

  // Bit shifted out of the top digit means the value no longer fits.
  assign adj_flat = adj;
  assign dig_next = {adj_flat[DW-2:0], shift_q[BIN_W-1]};
  assign carry = adj_flat[DW-1];
  assign top_bad = dig_next[DW-1 -: 4] > 4'd9;

  always_comb begin
    logic lead;
    loaded = dig_q;
    lead = BLANK_EN;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && dig_q[i] == 4'd0) loaded[i] = BCD_BLANK;
      else lead = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    dig_d = dig_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sb.start) begin
          shift_d = sb.bin_in;
          dig_d = '0;
          cnt_d = '0;
          acc_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_q << 1;
        dig_d = dig_next;
        acc_d = acc_q | carry | top_bad;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        bcd_d = acc_q ? SAT : loaded;
        ovf_d = acc_q;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      dig_q <= '0;
      cnt_q <= '0;
      acc_q <= 1'b0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dig_q <= dig_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  end

  assign sb.busy = (state_q != IDLE);
  assign sb.done = done_q;
  assign sb.bcd_out = bcd_q;
  assign sb.ovf = ovf_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Bench for score_bcd_converter: 7-digit and 4-digit instances
// checked against an arithmetic decimal-digit model.
module tb_score_bcd_converter;
  import score_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 Clk = ~Clk;

  score_bcd_converter_if #(.BIN_W(20), .DIGITS(7)) a_if ();
  score_bcd_converter_if #(.BIN_W(20), .DIGITS(4)) b_if ();

  score_bcd_converter #(.BIN_W(20), .DIGITS(7)) u_a (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .sb      (a_if)
  );

  score_bcd_converter #(.BIN_W(20), .DIGITS(4)) u_b (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .sb      (b_if)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal digits from division; leading digit i is blank iff v < 10^i.
  task automatic ref_model(input int unsigned v, input int digits,
                           output logic [27:0] bcd, output logic ovf);
    longint unsigned lim = 1;
    int unsigned t = v;
    longint unsigned p = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    bcd = '0;
    if (longint'(v) > lim - 1) begin
      ovf = 1'b1;
      for (int i = 0; i < digits; i++) bcd[4*i +: 4] = 4'h9;
    end else begin
      ovf = 1'b0;
      for (int i = 0; i < digits; i++) begin
        bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
`ifdef SCORE_BCD_BLANK_EN
      for (int i = 1; i < digits; i++) begin
        p = p * 10;
        if (longint'(v) < p) bcd[4*i +: 4] = BCD_BLANK;
      end
`endif
    end
  endtask

  function automatic logic [27:0] get_bcd(input bit sel);
    return sel ? {12'h0, b_if.bcd_out} : a_if.bcd_out;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? b_if.busy : a_if.busy;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? b_if.done : a_if.done;
  endfunction

  function automatic logic get_ovf(input bit sel);
    return sel ? b_if.ovf : a_if.ovf;
  endfunction

  task automatic drive(input bit sel, input logic s, input logic [19:0] v);
    if (sel) begin
      b_if.start = s;
      b_if.bin_in = v;
    end else begin
      a_if.start = s;
      a_if.bin_in = v;
    end
  endtask

  task automatic convert(input bit sel, input logic [19:0] v, input string tag);
    logic [27:0] prev, exp_bcd;
    logic exp_ovf;
    int n, busy_n;
    bit partial;
    ref_model(v, sel ? 4 : 7, exp_bcd, exp_ovf);
    @(negedge Clk);
    drive(sel, 1'b1, v);
    prev = get_bcd(sel);
    @(posedge Clk);
    #1;
    drive(sel, 1'b0, 20'($urandom));
    busy_n = get_busy(sel) ? 1 : 0;
    n = 0;
    partial = 1'b0;
    while (!get_done(sel) && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
      if (get_busy(sel)) busy_n++;
      if (!get_done(sel) && get_bcd(sel) !== prev) partial = 1'b1;
    end
    check({tag, " latency"}, 64'(n), 64'd21);
    check({tag, " busy_cycles"}, 64'(busy_n), 64'd21);
    check({tag, " no_partial"}, 64'(partial), 64'd0);
    check({tag, " bcd"}, 64'(get_bcd(sel)), 64'(exp_bcd));
    check({tag, " ovf"}, 64'(get_ovf(sel)), 64'(exp_ovf));
    @(posedge Clk);
    #1;
    check({tag, " done_pulse"}, 64'(get_done(sel)), 64'd0);
    check({tag, " hold"}, 64'(get_bcd(sel)), 64'(exp_bcd));
  endtask

  initial begin
    logic [27:0] exp_bcd, cap;
    logic exp_ovf;
    int dones;
    drive(1'b0, 1'b0, 20'd0);
    drive(1'b1, 1'b0, 20'd0);
    repeat (3) @(posedge Clk);
    #1;
    check("reset busy", 64'(a_if.busy), 64'd0);
    check("reset done", 64'(a_if.done), 64'd0);
    check("reset bcd", 64'(a_if.bcd_out), 64'd0);
    check("reset ovf", 64'(a_if.ovf), 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    convert(1'b0, 20'd0, "zero");
    convert(1'b0, 20'd1048575, "max");
    convert(1'b0, 20'd200, "d200");
    convert(1'b1, 20'd12345, "d4_ovf");
    convert(1'b1, 20'd9999, "d4_9999");
    convert(1'b1, 20'd10000, "d4_10000");
    for (int i = 0; i < 6; i++) convert(1'b0, 20'($urandom), "rand7");
    for (int i = 0; i < 5; i++)
      convert(1'b1, 20'($urandom_range(0, 20000)), "rand4");

    // A start while busy must be dropped, not queued.
    ref_model(510, 7, exp_bcd, exp_ovf);
    @(negedge Clk);
    drive(1'b0, 1'b1, 20'd510);
    @(posedge Clk);
    #1;
    drive(1'b0, 1'b0, 20'd0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    drive(1'b0, 1'b1, 20'd777);
    @(posedge Clk);
    #1;
    drive(1'b0, 1'b0, 20'd0);
    dones = 0;
    cap = '0;
    for (int i = 0; i < 50; i++) begin
      @(posedge Clk);
      #1;
      if (a_if.done) begin
        dones++;
        cap = a_if.bcd_out;
      end
    end
    check("ignore dones", 64'(dones), 64'd1);
    check("ignore bcd", 64'(cap), 64'(exp_bcd));
    check("ignore busy", 64'(a_if.busy), 64'd0);
    convert(1'b0, 20'd777, "d777");

    // Reset in the middle of a conversion.
    @(negedge Clk);
    drive(1'b0, 1'b1, 20'd1234);
    @(posedge Clk);
    #1;
    drive(1'b0, 1'b0, 20'd0);
    repeat (9) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    check("abort busy", 64'(a_if.busy), 64'd0);
    check("abort bcd", 64'(a_if.bcd_out), 64'd0);
    check("abort ovf", 64'(a_if.ovf), 64'd0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1;
      if (a_if.done) dones++;
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk);
      #1;
      if (a_if.done) dones++;
    end
    check("abort no_done", 64'(dones), 64'd0);
    convert(1'b0, 20'd50, "after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
